// File: rtl/libv_cpa_seq.sv
// Sequential carry-propagate adder: resolves a carry-save pair into a binary
// result, rippling the carry across W/CHUNK chunks at one chunk per cycle.
module libv_cpa_seq #(
    parameter int W     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_s,
    input  logic [W-1:0] in_c,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_sum,
    output logic         out_co
);

    localparam int NCHUNK = W / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if (CHUNK < 1 || (W % CHUNK) != 0) begin : g_bad_chunk
            $error("libv_cpa_seq: CHUNK must divide W exactly");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     s_q;
    logic [W-1:0]     c_q;
    logic [W-1:0]     sum_q;
    logic             carry_q;
    logic [KW-1:0]    k_q;
    logic             accept;
    logic             last_chunk;
    logic [CHUNK:0]   chunk_sum;

    assign accept     = in_vld & in_rdy;
    assign last_chunk = (k_q == KW'(NCHUNK - 1));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_vld) state_nxt = BUSY;
            BUSY:    if (last_chunk) state_nxt = DONE;
            DONE:    if (out_rdy) state_nxt = in_vld ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_rdy  = (state == IDLE) || ((state == DONE) && out_rdy);
        out_vld = (state == DONE);
    end

    // Operands shift down one chunk per cycle so the low chunk is always the
    // one being resolved; results enter at the top and settle into place.
    assign chunk_sum = {1'b0, s_q[CHUNK-1:0]} + {1'b0, c_q[CHUNK-1:0]}
                     + (CHUNK+1)'(carry_q);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s_q     <= '0;
            c_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
        end else if (accept) begin
            s_q     <= in_s;
            c_q     <= in_c;
            carry_q <= 1'b0;
            k_q     <= '0;
        end else if (state == BUSY) begin
            s_q     <= s_q >> CHUNK;
            c_q     <= c_q >> CHUNK;
            sum_q   <= (sum_q >> CHUNK) | (W'(chunk_sum[CHUNK-1:0]) << (W - CHUNK));
            carry_q <= chunk_sum[CHUNK];
            k_q     <= k_q + KW'(1);
        end
    end

    // After the final chunk the carry register holds the word's carry-out and
    // stays untouched until the next pair is accepted.
    assign out_sum = sum_q;
    assign out_co  = carry_q;

endmodule

// File: tb/tb_libv_cpa_seq.sv
// Directed checks for libv_cpa_seq (W=32 with CHUNK=8 and CHUNK=32), plus a
// randomized stream with stalls checked in order against a queue of sums.
module tb_libv_cpa_seq;

    logic        clk;
    logic        arst_n;
    logic        in_vld;
    logic        in_rdy;
    logic [31:0] in_s;
    logic [31:0] in_c;
    logic        out_vld;
    logic        out_rdy;
    logic [31:0] out_sum;
    logic        out_co;

    logic        in_vld2;
    logic        in_rdy2;
    logic        out_vld2;
    logic        out_rdy2;
    logic [31:0] out_sum2;
    logic        out_co2;

    int nvec;
    int nerr;

    libv_cpa_seq #(.W(32), .CHUNK(8)) dut (
        .clk     (clk),
        .arst_n  (arst_n),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in_s    (in_s),
        .in_c    (in_c),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_sum (out_sum),
        .out_co  (out_co)
    );

    libv_cpa_seq #(.W(32), .CHUNK(32)) dut32 (
        .clk     (clk),
        .arst_n  (arst_n),
        .in_vld  (in_vld2),
        .in_rdy  (in_rdy2),
        .in_s    (in_s),
        .in_c    (in_c),
        .out_vld (out_vld2),
        .out_rdy (out_rdy2),
        .out_sum (out_sum2),
        .out_co  (out_co2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with the DUT able to accept.
    task automatic run_pair(input string tag, input logic [31:0] s, input logic [31:0] c,
                            input logic [32:0] exp);
        int cnt;
        in_s   = s;
        in_c   = c;
        in_vld = 1'b1;
        #1;
        check({tag, "_in_rdy"}, 64'(in_rdy), 64'd1);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) in_vld = 1'b0;
        end while (!out_vld && cnt < 20);
        check({tag, "_latency"}, 64'(cnt - 1), 64'd4);
        check({tag, "_result"}, 64'({out_co, out_sum}), 64'(exp));
    endtask

    logic [32:0] exp_q[$];
    int          sent;
    int          got;
    int          cyc;
    int          cnt2;

    initial begin
        nvec     = 0;
        nerr     = 0;
        arst_n   = 1'b0;
        in_vld   = 1'b0;
        in_s     = '0;
        in_c     = '0;
        out_rdy  = 1'b1;
        in_vld2  = 1'b0;
        out_rdy2 = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_out", 64'({out_vld, out_co, out_sum}), 64'd0);
        check("rst_in_rdy", 64'(in_rdy), 64'd1);
        check("rst_out32", 64'({out_vld2, out_co2, out_sum2}), 64'd0);
        arst_n = 1'b1;
        @(negedge clk);

        // Plain add and a carry that ripples through every chunk
        run_pair("t1", 32'h12345678, 32'h11111111, 33'h0_23456789);
        run_pair("t2", 32'h00000001, 32'hFFFFFFFF, 33'h1_00000000);

        // Backpressure: result must hold while out_rdy is low
        @(negedge clk);
        out_rdy = 1'b0;
        run_pair("t3_first", 32'h0F0F0F0F, 32'h01010101, 33'h0_10101010);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_hold", 64'({out_vld, in_rdy, out_co, out_sum}), {29'd0, 3'b100, 32'h10101010});
        end
        @(negedge clk);
        out_rdy = 1'b1;
        run_pair("t3_accept", 32'd5, 32'd7, 33'd12);

        // Reset two cycles into BUSY abandons the work in flight
        @(negedge clk);
        in_s   = 32'h00001234;
        in_c   = 32'h00000001;
        in_vld = 1'b1;
        @(negedge clk);
        in_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        check("t4_rst_out", 64'({out_vld, out_co, out_sum}), 64'd0);
        @(negedge clk);
        check("t4_rst_hold", 64'({out_vld, out_co, out_sum}), 64'd0);
        arst_n = 1'b1;
        #1;
        check("t4_in_rdy", 64'(in_rdy), 64'd1);
        run_pair("t4_next", 32'h80000000, 32'h80000000, 33'h1_00000000);

        // Single-chunk instance resolves in one cycle
        @(negedge clk);
        in_s    = 32'hAAAAAAAA;
        in_c    = 32'h55555555;
        in_vld2 = 1'b1;
        #1;
        check("t5_in_rdy", 64'(in_rdy2), 64'd1);
        cnt2 = 0;
        do begin
            @(negedge clk);
            cnt2++;
            if (cnt2 == 1) in_vld2 = 1'b0;
        end while (!out_vld2 && cnt2 < 20);
        check("t5_latency", 64'(cnt2 - 1), 64'd1);
        check("t5_result", 64'({out_co2, out_sum2}), 64'h0_FFFFFFFF);

        // Random stream with stalls on both sides
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 1000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            in_s    = $urandom;
            in_c    = ($urandom_range(0, 7) == 0) ? ~in_s + 32'(($urandom_range(0, 1))) : $urandom;
            in_vld  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            out_rdy = ($urandom_range(0, 3) != 0);
            #1;
            if (out_vld && out_rdy) begin
                check("rnd_order", 64'({out_co, out_sum}),
                      (exp_q.size() > 0) ? 64'(exp_q.pop_front()) : {64{1'bx}});
                got++;
            end
            if (in_vld && in_rdy) begin
                exp_q.push_back({1'b0, in_s} + {1'b0, in_c});
                sent++;
            end
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        check("rnd_count", 64'(got), 64'd1000);
        check("rnd_leftover", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
